// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped cache controller: default
// geometry, FSM state encoding and a constant-width log2 helper.
package cache_pkg;

  localparam int ADDR_W_DEF  = 15;
  localparam int INDEX_W_DEF = 10;
  localparam int WORDS_DEF   = 4;
  localparam int DATA_W_DEF  = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_RESP   = 2'd2,
    ST_WRITE  = 2'd3
  } state_t;

  // Ceiling log2 for elaboration-time widths (value >= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_if.sv
// CPU-side and memory-side handshake bundle of the cache. The master
// modport is the environment (CPU plus memory); the slave modport is the
// cache controller.
interface cache_if
  import cache_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              flush;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/cache_array.sv
// Tag and data storage of the cache: one synchronous write port with a
// per-word enable plus a separate tag write, and combinational read of
// the tag and one word. Storage is intentionally not reset.
module cache_array
  import cache_pkg::*;
#(
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int WORDS   = WORDS_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TAG_W   = 3,
  localparam int OFF_W  = clog2(WORDS),
  localparam int LINES  = 1 << INDEX_W
) (
  input  logic               clk_i,
  input  logic [INDEX_W-1:0] wr_index_i,
  input  logic [WORDS-1:0]   word_en_i,
  input  logic [DATA_W-1:0]  wr_data_i,
  input  logic               tag_we_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [INDEX_W-1:0] rd_index_i,
  input  logic [OFF_W-1:0]   rd_offset_i,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [DATA_W-1:0]  rd_data_o
);

  logic [TAG_W-1:0]              tag_mem  [LINES];
  logic [WORDS-1:0][DATA_W-1:0]  data_mem [LINES];

  // Word-enabled line write and tag write, both on the same index.
  always_ff @(posedge clk_i) begin
    for (int w = 0; w < WORDS; w++) begin
      if (word_en_i[w]) data_mem[wr_index_i][w] <= wr_data_i;
    end
    if (tag_we_i) tag_mem[wr_index_i] <= wr_tag_i;
  end

  assign rd_tag_o  = tag_mem[rd_index_i];
  assign rd_data_o = data_mem[rd_index_i][rd_offset_i];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Read hits complete combinationally in IDLE; misses refill a whole line
// word by word; writes always go to memory and update the line on a hit.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int WORDS   = WORDS_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  cache_if.slave      bus,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int OFF_W = clog2(WORDS);
  localparam int TAG_W = ADDR_W - INDEX_W - OFF_W;
  localparam int LINES = 1 << INDEX_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t             state_q, state_d;
  logic [OFF_W-1:0]   cnt_q, cnt_d;
  logic [LINES-1:0]   valid_q;
  logic [15:0]        hit_cnt_q, miss_cnt_q;

  logic [OFF_W-1:0]   offset;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic [TAG_W-1:0]   rd_tag;
  logic [DATA_W-1:0]  rd_data;
  logic               lookup_hit;
  logic               idle_accept;

  logic [WORDS-1:0]   word_en;
  logic [DATA_W-1:0]  wr_data;
  logic               tag_we;
  logic               set_valid;
  logic               hit_pulse;
  logic               miss_pulse;

  assign offset = bus.cpu_addr[OFF_W-1:0];
  assign index  = bus.cpu_addr[OFF_W +: INDEX_W];
  assign tag    = bus.cpu_addr[ADDR_W-1 -: TAG_W];

  assign lookup_hit  = valid_q[index] && (rd_tag == tag);
  // A flush in IDLE wins over a simultaneous request.
  assign idle_accept = (state_q == ST_IDLE) && bus.cpu_req && !bus.flush;

  cache_array #(
    .INDEX_W (INDEX_W),
    .WORDS   (WORDS),
    .DATA_W  (DATA_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk_i       (clk),
    .wr_index_i  (index),
    .word_en_i   (word_en),
    .wr_data_i   (wr_data),
    .tag_we_i    (tag_we),
    .wr_tag_i    (tag),
    .rd_index_i  (index),
    .rd_offset_i (offset),
    .rd_tag_o    (rd_tag),
    .rd_data_o   (rd_data)
  );

  // FSM state and refill word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (idle_accept) begin
          if (bus.cpu_we) begin
            state_d = ST_WRITE;
          end else if (!lookup_hit) begin
            state_d = ST_REFILL;
            cnt_d   = '0;
          end
        end
      end
      ST_REFILL: begin
        if (bus.mem_ack) begin
          cnt_d = cnt_q + OFF_W'(1);
          if (cnt_q == LAST_WORD) state_d = ST_RESP;
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      ST_WRITE: if (bus.mem_ack) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs, array write controls and counter events per state.
  always_comb begin
    bus.cpu_ready = 1'b0;
    bus.cpu_rdata = rd_data;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wdata = bus.cpu_wdata;
    word_en       = '0;
    wr_data       = bus.mem_rdata;
    tag_we        = 1'b0;
    set_valid     = 1'b0;
    hit_pulse     = 1'b0;
    miss_pulse    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (idle_accept && !bus.cpu_we) begin
          if (lookup_hit) begin
            bus.cpu_ready = 1'b1;
            hit_pulse     = 1'b1;
          end else begin
            miss_pulse    = 1'b1;
          end
        end
      end
      ST_REFILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {tag, index, cnt_q};
        if (bus.mem_ack) begin
          word_en = WORDS'(1) << cnt_q;
          if (cnt_q == LAST_WORD) begin
            tag_we    = 1'b1;
            set_valid = 1'b1;
          end
        end
      end
      ST_RESP: bus.cpu_ready = 1'b1;
      ST_WRITE: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        if (bus.mem_ack) begin
          bus.cpu_ready = 1'b1;
          wr_data       = bus.cpu_wdata;
          if (lookup_hit) word_en = WORDS'(1) << offset;
        end
      end
      default: ;
    endcase
  end

  // Valid bits: cleared by reset or an IDLE flush, set when a refill completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if ((state_q == ST_IDLE) && bus.flush) begin
      valid_q <= '0;
    end else if (set_valid) begin
      valid_q[index] <= 1'b1;
    end
  end

  // Saturating read hit / refill-entry counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_pulse)  hit_cnt_q  <= sat_inc(hit_cnt_q);
      if (miss_pulse) miss_cnt_q <= sat_inc(miss_cnt_q);
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized scoreboard bench for cache_ctrl. The reference model keeps a
// plain memory image plus per-index valid/tag, so every read must return
// the memory word and hit exactly when the model says the line is present.
module tb_cache_ctrl;

  localparam int ADDR_W  = 15;
  localparam int INDEX_W = 10;
  localparam int WORDS   = 4;
  localparam int DATA_W  = 32;

  logic        clk;
  logic        rst_n;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  cache_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  cache_ctrl #(
    .ADDR_W  (ADDR_W),
    .INDEX_W (INDEX_W),
    .WORDS   (WORDS),
    .DATA_W  (DATA_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  typedef struct { bit we; logic [31:0] data; } exp_t;
  typedef struct { logic [14:0] addr; logic [31:0] data; } wr_t;

  int tests = 0;
  int fails = 0;

  exp_t        sb_q[$];
  logic [14:0] refill_q[$];
  wr_t         wr_q[$];

  logic [31:0] mem     [32768];
  logic [31:0] ref_mem [32768];
  bit          mvalid  [1024];
  logic [2:0]  mtag    [1024];
  int          m_hits;
  int          m_miss;
  int          acks_left = -1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  function automatic void model_flush();
    foreach (mvalid[i]) mvalid[i] = 1'b0;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory device: random-latency acks, checks refill and write addresses.
  initial begin
    wr_t w;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (rst_n && bus.mem_req && acks_left != 0 && $urandom_range(0, 2) != 0) begin
        bus.mem_ack = 1'b1;
        if (acks_left > 0) acks_left--;
        if (bus.mem_we) begin
          if (wr_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL mem_write_unexpected actual=%0h required=none", bus.mem_addr);
          end else begin
            w = wr_q.pop_front();
            chk("mem_wr_addr", 32'(bus.mem_addr), 32'(w.addr));
            chk("mem_wr_data", bus.mem_wdata, w.data);
          end
          mem[bus.mem_addr] = bus.mem_wdata;
        end else begin
          if (refill_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL refill_unexpected actual=%0h required=none", bus.mem_addr);
          end else begin
            chk("refill_addr", 32'(bus.mem_addr), 32'(refill_q.pop_front()));
          end
          bus.mem_rdata = mem[bus.mem_addr];
        end
      end
    end
  end

  // Response monitor: every cpu_ready pops one expected completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (bus.cpu_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL ready_unexpected actual=1 required=0");
        end else begin
          e = sb_q.pop_front();
          chk("resp_kind", 32'(bus.cpu_we), 32'(e.we));
          if (!e.we) chk("rdata", bus.cpu_rdata, e.data);
        end
      end
    end
  end

  task automatic do_access(input bit we, input logic [14:0] addr,
                           input logic [31:0] wd, input bit with_flush);
    logic [9:0] idx;
    logic [2:0] tg;
    bit         exp_hit;
    int         cyc;
    exp_t       e;
    wr_t        w;
    idx = addr[11:2];
    tg  = addr[14:12];
    @(negedge clk);
    if (with_flush) model_flush();
    exp_hit = mvalid[idx] && (mtag[idx] == tg);
    if (!we) begin
      e.we = 1'b0; e.data = ref_mem[addr];
      sb_q.push_back(e);
      if (exp_hit) begin
        if (m_hits < 65535) m_hits++;
      end else begin
        if (m_miss < 65535) m_miss++;
        for (int k = 0; k < WORDS; k++) refill_q.push_back({addr[14:2], 2'(k)});
        mvalid[idx] = 1'b1;
        mtag[idx]   = tg;
      end
    end else begin
      e.we = 1'b1; e.data = wd;
      sb_q.push_back(e);
      w.addr = addr; w.data = wd;
      wr_q.push_back(w);
      ref_mem[addr] = wd;
    end
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    if (with_flush) begin
      bus.flush = 1'b1;
      #1;
      chk("flush_blocks_ready", 32'(bus.cpu_ready), 32'd0);
      @(negedge clk);
      bus.flush = 1'b0;
    end
    cyc = 0;
    #1;
    while (bus.cpu_ready !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 200) begin
      tests++; fails++;
      $display("FAIL access_timeout actual=no_ready required=ready addr=%0h we=%0d", addr, we);
    end else if (!we && !with_flush) begin
      chk("hit_latency", 32'(cyc == 0), 32'(exp_hit));
    end
    @(negedge clk);
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    #1;
    chk("hit_count", 32'(hit_count), 32'(m_hits));
    chk("miss_count", 32'(miss_count), 32'(m_miss));
  endtask

  task automatic do_flush();
    @(negedge clk);
    bus.flush = 1'b1;
    model_flush();
    @(negedge clk);
    bus.flush = 1'b0;
  endtask

  initial begin
    int cyc;
    logic [14:0] ra;
    int r;
    rst_n         = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.flush     = 1'b0;
    m_hits        = 0;
    m_miss        = 0;
    model_flush();
    for (int i = 0; i < 32768; i++) mem[i] = $urandom;
    mem[4] = 32'hA0; mem[5] = 32'hA1; mem[6] = 32'hA2; mem[7] = 32'hA3;
    for (int i = 0; i < 32768; i++) ref_mem[i] = mem[i];

    repeat (3) @(negedge clk);
    #1;
    chk("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_hit_count", 32'(hit_count), 32'd0);
    chk("rst_miss_count", 32'(miss_count), 32'd0);
    rst_n = 1'b1;

    // Cold miss, then hit in the refilled line.
    do_access(1'b0, 15'h0005, 32'h0, 1'b0);
    do_access(1'b0, 15'h0006, 32'h0, 1'b0);
    // Write hit, read back.
    do_access(1'b1, 15'h0006, 32'hDEAD, 1'b0);
    do_access(1'b0, 15'h0006, 32'h0, 1'b0);
    // Write miss, then read misses and refills from 0x1000.
    do_access(1'b1, 15'h1000, 32'h1234, 1'b0);
    do_access(1'b0, 15'h1000, 32'h0, 1'b0);
    // Conflict on index 1.
    do_access(1'b0, 15'h1005, 32'h0, 1'b0);
    do_access(1'b0, 15'h0005, 32'h0, 1'b0);
    // Flush together with a read.
    do_access(1'b0, 15'h0005, 32'h0, 1'b1);

    // Reset in the middle of a refill after two acks.
    do_flush();
    acks_left = 2;
    @(negedge clk);
    refill_q.push_back(15'h0004);
    refill_q.push_back(15'h0005);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 15'h0005;
    cyc = 0;
    while (acks_left != 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 200) begin
      tests++; fails++;
      $display("FAIL midrefill_acks actual=%0d required=0", acks_left);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("midrst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
    chk("midrst_hit_count", 32'(hit_count), 32'd0);
    chk("midrst_miss_count", 32'(miss_count), 32'd0);
    chk("midrst_acks_used", 32'(refill_q.size()), 32'd0);
    refill_q.delete();
    bus.cpu_req = 1'b0;
    model_flush();
    m_hits    = 0;
    m_miss    = 0;
    acks_left = -1;
    @(negedge clk);
    rst_n = 1'b1;
    do_access(1'b0, 15'h0005, 32'h0, 1'b0);

    // Random traffic over a few indices and tags to force hits and conflicts.
    for (int n = 0; n < 300; n++) begin
      r  = $urandom_range(0, 19);
      ra = {3'($urandom_range(0, 2)), 10'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      if (r == 0) do_flush();
      else do_access(r < 6, ra, $urandom, 1'b0);
    end

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chk("refill_drained", 32'(refill_q.size()), 32'd0);
    chk("writes_drained", 32'(wr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_W, 15, word-address width.
- INDEX_W, 10, index bits; line count is 2**INDEX_W.
- WORDS, 4, words per line; must be a power of 2 and at least 2.
- DATA_W, 32, word width.
- TAG_W is derived, not a parameter: TAG_W = ADDR_W - INDEX_W - log2(WORDS).
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  read data.
- cpu_ready  out  1  access complete.
- flush  in  1  invalidate all lines.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_ack  in  1  memory transfer done.
- hit_count  out  16  read hits.
- miss_count  out  16  read misses.
REQ-003 Address split SHALL be: offset = cpu_addr[log2(WORDS)-1:0]; index = the next INDEX_W bits; tag = the top TAG_W bits.

Function
REQ-004 Organisation SHALL be direct-mapped, write-through, no-write-allocate.
REQ-005 FSM states SHALL be IDLE, REFILL, RESP, WRITE.
REQ-006 A read hit in IDLE SHALL return cpu_rdata and assert cpu_ready in the same cycle, with zero wait states.
REQ-007 A read miss in IDLE SHALL go to REFILL and clear the word counter.
REQ-008 REFILL behaviour:
- mem_req = 1, mem_we = 0.
- mem_addr = {tag, index, counter}.
- Each mem_ack stores mem_rdata into word[counter] and increments counter.
- The ack on counter = WORDS-1 writes the tag, sets valid, and moves to RESP.
REQ-009 RESP SHALL assert cpu_ready for one cycle with the requested word, then return to IDLE.
REQ-010 A write in IDLE SHALL go to WRITE.
- WRITE drives mem_req = 1, mem_we = 1, mem_addr = cpu_addr, mem_wdata = cpu_wdata until mem_ack.
- On the ack cycle: cpu_ready = 1; if the line hits, the cached word is updated; return to IDLE.
- A write miss SHALL leave the line unchanged.
REQ-011 Handshake rules:
- cpu_req, cpu_we, cpu_addr and cpu_wdata SHALL be held stable by the CPU until cpu_ready.
- mem_addr and mem_wdata SHALL stay stable while mem_req = 1.
- mem_ack SHALL be ignored when mem_req = 0.
- mem_ack may arrive the same cycle as mem_req.
REQ-012 flush SHALL be sampled only in IDLE. It clears all valid bits in one cycle and has priority over a simultaneous cpu_req; that request is not accepted in that cycle (cpu_ready = 0).
REQ-013 hit_count SHALL increment on each read hit and miss_count on each REFILL entry. Both saturate at 16'hFFFF. Writes are not counted.
REQ-014 cpu_ready SHALL be 0 in every state and cycle not listed above. cpu_rdata is don't-care when cpu_ready = 0.

Reset
REQ-015 rst_n low SHALL asynchronously set:
- state = IDLE, counter = 0;
- all valid bits = 0;
- mem_req = 0, mem_we = 0;
- cpu_ready = 0;
- hit_count = 0, miss_count = 0.
REQ-016 Tag and data storage SHALL NOT be reset.
REQ-017 Reset during REFILL or WRITE SHALL abort the access. No line is validated, and mem_req drops immediately.

Structure
REQ-018 Package cache_pkg SHALL hold the state encoding, parameter defaults, and a clog2 helper.
REQ-019 One sub-module, cache_array, SHALL hold the tag/data storage: 1 write port with word-enable and combinational read, no reset. Valid bits, FSM, and counters stay in cache_ctrl.

Verification (defaults)
REQ-020 Cold read miss: after reset, read 0x0005.
- Memory acks 0x0004..0x0007 with 0xA0..0xA3.
- Required: ready in RESP with rdata 0xA1; miss_count = 1.
- Then read 0x0006: ready same cycle, rdata 0xA2, hit_count = 1.
REQ-021 Write hit: write 0x0006 = 0xDEAD.
- Required: one mem write to 0x0006; ready on the ack cycle.
- Then read 0x0006: hit, rdata 0xDEAD.
REQ-022 Write miss: write 0x1000 = 0x1234.
- Required: mem write occurs.
- Then read 0x1000: miss with 4-word refill from 0x1000.
REQ-023 Conflict: with line 0x0004 valid, read 0x1005 (same index, tag 1).
- Required: refill from 0x1004.
- Then read 0x0005: miss again.
REQ-024 Flush priority: assert flush and a read of 0x0005 in the same cycle.
- Required: cpu_ready = 0 that cycle.
- The following cycle the read misses and refills.
REQ-025 Reset mid-refill: assert rst_n low after 2 of 4 acks.
- Required: mem_req = 0 immediately; counters = 0.
- After release, read 0x0005 misses.
